// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus transmitter handshake, bundled for fifo_rd_drain.
// The master modport is the drain side; the slave modport is the FIFO/transmitter side.
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;

    modport master (
        input  rempty, rdata, tx_busy,
        output rinc, tx_data, tx_valid
    );

    modport slave (
        output rempty, rdata, tx_busy,
        input  rinc, tx_data, tx_valid
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-domain consumer of the dual-clock FIFO: pops one word per frame, hands
// it to a serial transmitter with a one-cycle start strobe, and waits for the
// transmitter to finish. Optional post-frame gap, a frame counter and a sticky
// start-timeout flag. Every output is a flop; nothing combinational reaches a port.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  err_clr,
    fifo_rd_drain_if.master       bus,
    output logic [15:0]           frame_cnt,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        POP        = 3'd1,
        SEND       = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4,
        GAP        = 3'd5
    } state_t;

    // Last count before giving up on the start, and last gap cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  rinc_q, rinc_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [15:0]           wait_cnt_q, wait_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic                  set_err;

    // Next-state and next-output logic; rinc/tx_valid are computed one state
    // ahead so they are high exactly while the FSM sits in POP/SEND.
    always_comb begin
        state_d     = state_q;
        rinc_d      = 1'b0;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        frame_cnt_d = frame_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        set_err     = 1'b0;

        case (state_q)
            IDLE: begin
                // Capture the head word on the same edge we commit to popping it.
                if (enable && !bus.rempty && !bus.tx_busy) begin
                    tx_data_d = bus.rdata;
                    rinc_d    = 1'b1;
                    state_d   = POP;
                end
            end
            POP: begin
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                wait_cnt_d = '0;
                state_d    = WAIT_START;
            end
            WAIT_START: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Re-present the same word; no new pop on a retry.
                    set_err    = 1'b1;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = '0;
                    if (GAP_CYCLES > 0) state_d = GAP;
                    else                state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // A timeout in the same cycle as a clear must stay visible.
        if (set_err)      timeout_err_d = 1'b1;
        else if (err_clr) timeout_err_d = 1'b0;
        else              timeout_err_d = timeout_err_q;
    end

    // State and output registers; reset drops any held word and suppresses rinc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rinc_q        <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rinc_q        <= rinc_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign bus.rinc     = rinc_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign frame_cnt    = frame_cnt_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side consumer for the dual-clock FIFO. Lives entirely in the read clock domain. Pops one word at a time when the FIFO is non-empty and presents it to a serial transmitter (UART TX style) over a valid/busy handshake. Adds optional inter-frame gap insertion, a transmitted-frame counter and a sticky start-timeout error.

## Interface

Parameters:
- DATA_WIDTH, 8: FIFO word and tx_data width.
- GAP_CYCLES, 0: idle cycles inserted after each frame, legal range 0..255.
- TIMEOUT, 1024: cycles to wait for tx_busy to rise after a tx_valid pulse, legal range 2..65535.

Ports:
- clk, in, 1: read-domain clock. Single clock for the whole block.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: permits new pops. Sampled only in IDLE.
- rempty, in, 1: FIFO empty flag, already synchronous to clk.
- rdata, in, DATA_WIDTH: FIFO head word. Valid whenever rempty=0.
- rinc, out, 1: FIFO pop strobe, one cycle per word.
- tx_busy, in, 1: transmitter busy.
- tx_data, out, DATA_WIDTH: registered word for the transmitter.
- tx_valid, out, 1: one-cycle start strobe to the transmitter.
- err_clr, in, 1: clears timeout_err.
- frame_cnt, out, 16: completed frames.
- timeout_err, out, 1: sticky start-timeout flag.

## Operation

- FSM states: IDLE, POP, SEND, WAIT_START, WAIT_DONE, GAP. All outputs are Moore or registered; no combinational input-to-output path.
- IDLE:
  - go = enable & ~rempty & ~tx_busy.
  - On go, capture tx_data <= rdata on the same edge and move to POP.
- POP: rinc=1 for exactly this cycle, then SEND. tx_data holds.
- SEND: tx_valid=1 for exactly this cycle, then WAIT_START. The wait counter clears.
- WAIT_START:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise the wait counter increments.
  - When the counter reaches TIMEOUT-1 with tx_busy still 0: set timeout_err and return to SEND. The same tx_data is re-presented; no new pop occurs.
- WAIT_DONE:
  - Stays while tx_busy=1.
  - On tx_busy=0, frame_cnt increments.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then IDLE.
- frame_cnt: 16-bit, wraps 16'hFFFF -> 0.
- timeout_err:
  - Set by a timeout, cleared by err_clr.
  - If set and clear happen in the same cycle, set wins.
- enable=0 outside IDLE: the current frame completes normally. Only the next pop is blocked.
- rempty rising while not in IDLE has no effect. Exactly one word is popped per frame.
- Reset mid-operation:
  - The word held in tx_data is dropped.
  - No rinc is issued during or after the reset cycle.
  - The FIFO is not otherwise touched.

## Timing

- Reset values: state=IDLE, rinc=0, tx_valid=0, tx_data=0, frame_cnt=0, timeout_err=0, wait and gap counters=0.
- If go is true in IDLE at cycle k:
  - rinc=1 in cycle k+1.
  - tx_valid=1 in cycle k+2.
  - tx_data is valid from cycle k+1 and stable until the next IDLE->POP edge.
- Minimum frame period, transmitter asserting busy the cycle after tx_valid and holding it B cycles: B+4+GAP_CYCLES cycles from one POP to the next.
- IDLE is re-entered at least 3 cycles after rinc, so the registered FIFO rempty has already reflected the pop. No double pop on the last word.
- Timeout retry: tx_valid re-pulses TIMEOUT+1 cycles after the previous tx_valid.

## Test plan

- Single word: FIFO holds 8'hA5, enable=1, transmitter busy for 10 cycles -> rinc pulses once, tx_valid one cycle later with tx_data=8'hA5; frame_cnt=1; no second rinc after FIFO empties.
- Burst of 4 words 8'h01..8'h04, GAP_CYCLES=3 -> four rinc pulses, tx_data in order 01,02,03,04; at least 3 idle cycles between WAIT_DONE exit and the next rinc; frame_cnt=4.
- Silent transmitter, TIMEOUT=16, FIFO holds 8'h3C -> tx_valid repeats every 17 cycles with tx_data=8'h3C; timeout_err=1 after the first timeout; only one rinc. Then busy responds -> frame completes; err_clr -> timeout_err=0.
- enable dropped during WAIT_DONE with 2 words queued -> current frame completes (frame_cnt +1), no further rinc until enable=1 returns.
- rst asserted during WAIT_START -> next cycle: all outputs at reset values, no rinc; after release with FIFO non-empty, the normal pop sequence restarts.
- frame_cnt preloaded near wrap (force 16'hFFFF) and one frame completes -> frame_cnt=0.
